// File: rtl/inst_fetcher_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : inst_fetcher_pkg                                                |
// | Brief    : Shared widths, types and helpers for the instruction fetcher.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package inst_fetcher_pkg;

  // Shared platform widths for the address bus and instruction word.
  localparam int ADDRESS_WIDTH = 32;
  localparam int ID_WIDTH      = 32;

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [ID_WIDTH-1:0]      inst_t;

  function automatic addr_t word_align(input addr_t addr);
    return {addr[ADDRESS_WIDTH-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetcher_icache_array.sv
// +----------------------------------------------------------------------------+
// | Module   : icache_array                                                    |
// | Brief    : Direct-mapped one-word-per-line store; async read, sync fill.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module icache_array
  import inst_fetcher_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX   = $clog2(LINES),
  parameter int TAG_W = ADDRESS_WIDTH - IDX - 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [IDX-1:0]   rd_idx_in,
  input  logic [TAG_W-1:0] rd_tag_in,
  output logic             hit_out,
  output logic [31:0]      rd_data_out,
  input  logic             wr_en_in,
  input  logic [IDX-1:0]   wr_idx_in,
  input  logic [TAG_W-1:0] wr_tag_in,
  input  logic [31:0]      wr_data_in
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [TAG_W-1:0] tag_d  [LINES];
  logic [31:0]      data_q [LINES];
  logic [31:0]      data_d [LINES];

  for (genvar i = 0; i < LINES; i++) begin : g_line
    always_comb begin
      valid_d[i] = valid_q[i];
      tag_d[i]   = tag_q[i];
      data_d[i]  = data_q[i];
      if (wr_en_in && (wr_idx_in == IDX'(i))) begin
        valid_d[i] = 1'b1;
        tag_d[i]   = wr_tag_in;
        data_d[i]  = wr_data_in;
      end
    end

    // Only the valid bits need reset; tag/data are qualified by them.
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) valid_q[i] <= 1'b0;
      else         valid_q[i] <= valid_d[i];
    end

    always_ff @(posedge clk_in) begin
      tag_q[i]  <= tag_d[i];
      data_q[i] <= data_d[i];
    end
  end

  assign hit_out     = valid_q[rd_idx_in] && (tag_q[rd_idx_in] == rd_tag_in);
  assign rd_data_out = data_q[rd_idx_in];

endmodule

`default_nettype wire

// File: rtl/inst_fetcher.sv
// +----------------------------------------------------------------------------+
// | Module   : inst_fetcher                                                    |
// | Brief    : PC owner, I-cache front end and RAM-controller word requester.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     jump_en_in,
  input  logic [ADDRESS_WIDTH-1:0] jump_addr_in,
  input  logic                     stall_in,
  output logic                     inst_valid_out,
  output logic [ID_WIDTH-1:0]      inst_out,
  output logic [ADDRESS_WIDTH-1:0] inst_pc_out,
  output logic                     mem_en_out,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_out,
  input  logic                     mem_rdy_in,
  input  logic [ID_WIDTH-1:0]      mem_inst_in
);

  localparam int IDX   = $clog2(ICACHE_LINES);
  localparam int TAG_W = ADDRESS_WIDTH - IDX - 2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_MISS = 1'b1;

  localparam addr_t RESET_PC_ALIGNED = word_align(RESET_PC);

  logic [0:0] state_q, state_d;
  addr_t      pc_q, pc_d;
  logic       inst_valid_q, inst_valid_d;
  inst_t      inst_q, inst_d;
  addr_t      inst_pc_q, inst_pc_d;
  logic       mem_en_q, mem_en_d;
  addr_t      mem_addr_q, mem_addr_d;

  logic       hit;
  inst_t      line_data;
  logic       fill_en;

  // A fill is a register update, so it is frozen by rdy_in like everything else.
  assign fill_en = rdy_in && (state_q == ST_MISS) && mem_rdy_in;

  icache_array #(
    .LINES (ICACHE_LINES)
  ) u_icache_array (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rd_idx_in   (pc_q[IDX+1:2]),
    .rd_tag_in   (pc_q[ADDRESS_WIDTH-1:IDX+2]),
    .hit_out     (hit),
    .rd_data_out (line_data),
    .wr_en_in    (fill_en),
    .wr_idx_in   (mem_addr_q[IDX+1:2]),
    .wr_tag_in   (mem_addr_q[ADDRESS_WIDTH-1:IDX+2]),
    .wr_data_in  (mem_inst_in)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    mem_en_d     = mem_en_q;
    mem_addr_d   = mem_addr_q;

    if (rdy_in) begin
      case (state_q)
        ST_RUN: begin
          inst_valid_d = 1'b0;
          if (jump_en_in) begin
            pc_d = word_align(jump_addr_in);
          end else if (stall_in) begin
            pc_d = pc_q;
          end else if (hit) begin
            inst_d       = line_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = pc_q;
            state_d    = ST_MISS;
          end
        end
        default: begin
          // The request stays in flight across a redirect; only pc moves.
          inst_valid_d = 1'b0;
          if (jump_en_in) pc_d = word_align(jump_addr_in);
          if (mem_rdy_in) begin
            mem_en_d = 1'b0;
            state_d  = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC_ALIGNED;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign inst_valid_out = inst_valid_q;
  assign inst_out       = inst_q;
  assign inst_pc_out    = inst_pc_q;
  assign mem_en_out     = mem_en_q;
  assign mem_addr_out   = mem_addr_q;

endmodule

`default_nettype wire
